shift_unit_pipe: RTL and testbench

//  Pipelined, parametrised shift/rotate unit for the integer execute path.

---
 rtl/shift_pkg.sv | 39 +++
 rtl/shift_unit_pipe_if.sv | 27 ++
 rtl/shift_slice.sv | 84 ++++++++
 rtl/shift_unit_pipe.sv | 84 ++++++++
 tb/tb_shift_unit_pipe.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shift/rotate unit.
// Exports: shift_op_e encodings, bitrev(), op classifiers.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SRL = 3'b000,
        OP_SRA = 3'b001,
        OP_SLL = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } shift_op_e;

    // Widest XLEN bitrev() can handle.
    localparam int MAX_XLEN = 128;

    // Reverse the low w bits of x; result is right-aligned.
    function automatic logic [MAX_XLEN-1:0] bitrev(
        input logic [MAX_XLEN-1:0] x,
        input int w
    );
        logic [MAX_XLEN-1:0] r;
        for (int i = 0; i < MAX_XLEN; i++)
            r[i] = x[MAX_XLEN-1-i];
        return r >> (MAX_XLEN - w);
    endfunction

    function automatic logic is_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic is_right(input logic [2:0] op);
        return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

    function automatic logic is_rot(input logic [2:0] op);
        return (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Issue-side and writeback-side handshake bundle of the shift unit.
// master = issue/writeback logic, slave = shift_unit_pipe.
interface shift_unit_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/shift_slice.sv
// One pipeline slice: right-shift mux levels [LO,HI) then a register.
// Ports: up_* from previous slice, dn_* to next slice; elastic handshake.
module shift_slice
    import shift_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int LO    = 0,
    parameter int HI    = 1,
    localparam int L    = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [XLEN-1:0]  up_data,
    input  logic [L-1:0]     up_shamt,
    input  logic [2:0]       up_op,
    input  logic             up_sign,
    input  logic [TAG_W-1:0] up_tag,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [XLEN-1:0]  dn_data,
    output logic [L-1:0]     dn_shamt,
    output logic [2:0]       dn_op,
    output logic             dn_sign,
    output logic [TAG_W-1:0] dn_tag
);
    logic             v;
    logic             adv;
    logic [XLEN-1:0]  x;
    logic [XLEN-1:0]  sh;
    logic [XLEN-1:0]  ones;
    logic             rot;
    logic             fill1;

    assign rot   = is_rot(up_op);
    assign fill1 = (up_op == OP_SRA) && up_sign;

    always_comb begin
        x    = up_data;
        sh   = '0;
        ones = '0;
        for (int k = LO; k < HI; k++) begin
            if (up_shamt[k]) begin
                sh   = x >> (1 << k);
                ones = ~({XLEN{1'b1}} >> (1 << k));
                unique case (1'b1)
                    rot:     x = sh | (x << (XLEN - (1 << k)));
                    fill1:   x = sh | ones;
                    default: x = sh;
                endcase
            end
        end
    end

    assign adv      = !v || dn_ready;
    assign up_ready = adv;
    assign dn_valid = v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v        <= 1'b0;
            dn_data  <= '0;
            dn_shamt <= '0;
            dn_op    <= '0;
            dn_sign  <= 1'b0;
            dn_tag   <= '0;
        end else begin
            if (flush)
                v <= 1'b0;
            else if (adv)
                v <= up_valid;
            if (adv && up_valid) begin
                dn_data  <= x;
                dn_shamt <= up_shamt;
                dn_op    <= up_op;
                dn_sign  <= up_sign;
                dn_tag   <= up_tag;
            end
        end
    end
endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined SRL/SRA/SLL/ROR/ROL unit, latency STAGES, 1 op/cycle.
// Ports: clk, rst_n, flush, bus (issue in_*, writeback out_*).
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input logic clk,
    input logic rst_n,
    input logic flush,
    shift_unit_pipe_if.slave bus
);
    localparam int L = $clog2(XLEN);

    logic [STAGES:0]             v;
    logic [STAGES:0]             rdy;
    logic [STAGES:0][XLEN-1:0]   d;
    logic [STAGES:0][L-1:0]      sh;
    logic [STAGES:0][2:0]        op;
    logic [STAGES:0]             sg;
    logic [STAGES:0][TAG_W-1:0]  tg;
    logic [XLEN-1:0]             a_rev;
    logic [XLEN-1:0]             r_rev;
    logic                        unused_top;

    // Left ops run through the right shifter on bit-reversed data.
    assign a_rev = XLEN'(bitrev(MAX_XLEN'(bus.in_a), XLEN));

    assign v[0]  = bus.in_valid;
    assign d[0]  = is_left(bus.in_op) ? a_rev : bus.in_a;
    assign sh[0] = bus.in_b[L-1:0];
    assign op[0] = bus.in_op;
    assign sg[0] = bus.in_a[XLEN-1];
    assign tg[0] = bus.in_tag;

    assign bus.in_ready = rdy[0];
    assign rdy[STAGES]  = bus.out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        shift_slice #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .LO    (s * L / STAGES),
            .HI    ((s == STAGES - 1) ? L : (s + 1) * L / STAGES)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (v[s]),
            .up_ready (rdy[s]),
            .up_data  (d[s]),
            .up_shamt (sh[s]),
            .up_op    (op[s]),
            .up_sign  (sg[s]),
            .up_tag   (tg[s]),
            .dn_valid (v[s+1]),
            .dn_ready (rdy[s+1]),
            .dn_data  (d[s+1]),
            .dn_shamt (sh[s+1]),
            .dn_op    (op[s+1]),
            .dn_sign  (sg[s+1]),
            .dn_tag   (tg[s+1])
        );
    end

    assign r_rev = XLEN'(bitrev(MAX_XLEN'(d[STAGES]), XLEN));

    // Undefined op codes still flow through and emerge as zero.
    always_comb begin
        bus.out_result = '0;
        unique case (1'b1)
            is_left(op[STAGES]):  bus.out_result = r_rev;
            is_right(op[STAGES]): bus.out_result = d[STAGES];
            default:              bus.out_result = '0;
        endcase
    end

    assign bus.out_valid = v[STAGES];
    assign bus.out_tag   = tg[STAGES];

    assign unused_top = ^{bus.in_b[XLEN-1:L], sh[STAGES], sg[STAGES]};
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe (XLEN=32, STAGES=2).
// Vector table, hand sequences and a random stream against a scoreboard.
module tb_shift_unit_pipe;
    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    shift_unit_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    shift_unit_pipe #(
        .XLEN   (XLEN),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            3'd0: return a >> s;
            3'd1: return 32'($signed(a) >>> s);
            3'd2: return a << s;
            3'd3: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            3'd4: return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            default: return 32'd0;
        endcase
    endfunction

    // Called just after a negedge with inputs set; ends on the next negedge.
    task automatic tick(input logic [31:0] e, output bit acc);
        exp_t it;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                chk("unexpected_out", 64'(bus.out_valid), 64'd0);
            end else begin
                it = q.pop_front();
                chk("result", 64'(bus.out_result), 64'(it.res));
                chk("tag", 64'(bus.out_tag), 64'(it.tag));
            end
        end
        acc = bus.in_valid && bus.in_ready;
        if (flush)
            q.delete();
        else if (acc)
            q.push_back('{res: e, tag: bus.in_tag});
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
    endtask

    task automatic drain();
        bit acc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4 * STAGES + 4 && q.size() > 0; i++)
            tick(32'd0, acc);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    vec_t tv[14];

    initial begin
        bit          acc;
        int          sent;
        int          out0;
        logic [31:0] held;
        logic [2:0]  o8[8];
        logic [31:0] a8[8];
        logic [31:0] b8[8];
        bit          pend;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rt;

        tv[0]  = '{3'd1, 32'h8000_0000, 32'd4,          32'hF800_0000};
        tv[1]  = '{3'd2, 32'h0000_0001, 32'h0000_003F,  32'h8000_0000};
        tv[2]  = '{3'd0, 32'hF000_0000, 32'd28,         32'h0000_000F};
        tv[3]  = '{3'd3, 32'h0000_00F1, 32'd4,          32'h1000_000F};
        tv[4]  = '{3'd4, 32'h8000_0001, 32'd1,          32'h0000_0003};
        tv[5]  = '{3'd0, 32'h1234_5678, 32'd0,          32'h1234_5678};
        tv[6]  = '{3'd1, 32'h7FFF_FFFF, 32'd31,         32'h0000_0000};
        tv[7]  = '{3'd1, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF};
        tv[8]  = '{3'd5, 32'hFFFF_FFFF, 32'd3,          32'h0000_0000};
        tv[9]  = '{3'd7, 32'h0000_1234, 32'd0,          32'h0000_0000};
        tv[10] = '{3'd4, 32'h1234_5678, 32'hFFFF_FF04,  32'h2345_6781};
        tv[11] = '{3'd3, 32'h1234_5678, 32'd8,          32'h7812_3456};
        tv[12] = '{3'd2, 32'hFFFF_FFFF, 32'd16,         32'hFFFF_0000};
        tv[13] = '{3'd1, 32'h8000_0000, 32'h0000_0020,  32'h8000_0000};

        set_in(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Latency: SRA result appears exactly STAGES cycles after accept
        bus.out_ready = 1'b1;
        set_in(1'b1, 3'd1, 32'h8000_0000, 32'd4, 5'd7);
        tick(32'hF800_0000, acc);
        chk("lat_accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        #1;
        chk("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
        tick(32'd0, acc);
        chk("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_result", 64'(bus.out_result), 64'hF800_0000);
        chk("lat_tag", 64'(bus.out_tag), 64'd7);
        drain();

        // Vector table, back to back
        for (int i = 0; i < 14; i++) begin
            set_in(1'b1, tv[i].op, tv[i].a, tv[i].b, 5'(i));
            tick(tv[i].exp, acc);
            chk("tv_accept", 64'(acc), 64'd1);
        end
        drain();

        // 8 ops with a 3-cycle output stall mid-stream
        for (int i = 0; i < 8; i++) begin
            o8[i] = 3'($urandom_range(0, 4));
            a8[i] = $urandom;
            b8[i] = $urandom;
        end
        sent = 0;
        out0 = n_out;
        held = '0;
        for (int c = 0; c < 24; c++) begin
            bus.out_ready = !(c >= 4 && c <= 6);
            if (sent < 8)
                set_in(1'b1, o8[sent], a8[sent], b8[sent], 5'(sent + 16));
            else
                bus.in_valid = 1'b0;
            #1;
            if (c == 4) begin
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
                held = bus.out_result;
            end
            if (c == 5 || c == 6) begin
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                chk("stall_held", 64'(bus.out_result), 64'(held));
            end
            tick(ref_shift(bus.in_op, bus.in_a, bus.in_b), acc);
            if (acc)
                sent++;
        end
        chk("stall_sent", 64'(sent), 64'd8);
        chk("stall_delivered", 64'(n_out - out0), 64'd8);
        drain();

        // Flush: one in flight, one accepted in the flush cycle
        bus.out_ready = 1'b0;
        set_in(1'b1, 3'd2, 32'h0000_00FF, 32'd4, 5'd1);
        tick(32'h0000_0FF0, acc);
        set_in(1'b1, 3'd0, 32'hFFFF_0000, 32'd8, 5'd2);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        tick(32'h00FF_FF00, acc);
        flush = 1'b0;
        bus.out_ready = 1'b1;
        set_in(1'b1, 3'd3, 32'h0000_0001, 32'd1, 5'd9);
        #1;
        chk("flush_killed", 64'(bus.out_valid), 64'd0);
        tick(32'h8000_0000, acc);
        chk("flush_next_accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        #1;
        chk("flush_gap", 64'(bus.out_valid), 64'd0);
        tick(32'd0, acc);
        chk("flush_resume_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_resume_tag", 64'(bus.out_tag), 64'd9);
        drain();

        // Random stream with random backpressure
        pend = 1'b0;
        rop = '0;
        ra = '0;
        rb = '0;
        rt = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                rop = 3'($urandom_range(0, 7));
                ra  = $urandom;
                rb  = $urandom;
                rt  = 5'($urandom);
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            set_in(bus.in_valid, rop, ra, rb, rt);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick(ref_shift(rop, ra, rb), acc);
            pend = bus.in_valid && !acc;
        end
        drain();

        // Asynchronous reset while the pipe is full and stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd0, 5'd31);
            tick(32'hFFFF_FFFF, acc);
        end
        bus.in_valid = 1'b0;
        chk("prerst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_result", 64'(bus.out_result), 64'd0);
        chk("midrst_out_tag", 64'(bus.out_tag), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
